// File: rtl/dvfs_domain_sequencer.sv
// DVFS and domain-gating sequencer for the NPU.
// Measures windowed peak utilisation, steps the operating level through a req/ack
// regulator handshake with settle time, applies thermal throttling with hysteresis,
// and clock/power gates idle domains (power restored before clock on wake).
// Optional: define PM_STATS_EN to build the committed-transition counter.
module dvfs_domain_sequencer #(
  parameter int unsigned NUM_DOMAINS   = 4,
  parameter int unsigned UTIL_W        = 16,
  parameter int unsigned LEVEL_W       = 3,
  parameter int unsigned LEVEL_INIT    = 3,
  parameter int unsigned WINDOW_LOG2   = 7,
  parameter int unsigned UP_THRESH     = 40000,
  parameter int unsigned DOWN_THRESH   = 15000,
  parameter int unsigned SETTLE_CYCLES = 50,
  parameter int unsigned TEMP_LIMIT    = 85,
  parameter int unsigned TEMP_HYST     = 5,
  parameter int unsigned GATE_THRESH   = 100,
  parameter int unsigned CG_DELAY      = 16,
  parameter int unsigned PG_DELAY      = 256
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic [NUM_DOMAINS*UTIL_W-1:0] util_flat_i,
  input  logic [7:0]                    temperature_i,
  output logic                          dvfs_req_o,
  output logic [LEVEL_W-1:0]            dvfs_target_o,
  input  logic                          dvfs_ack_i,
  output logic [LEVEL_W-1:0]            level_o,
  output logic                          thermal_throttle_o,
  output logic [NUM_DOMAINS-1:0]        domain_pwr_en_o,
  output logic [NUM_DOMAINS-1:0]        domain_clk_en_o,
  output logic                          busy_o,
  output logic [15:0]                   dvfs_transitions_o
);

  localparam int unsigned AccW  = UTIL_W + WINDOW_LOG2;
  localparam int unsigned IdleW = $clog2(PG_DELAY + 1);
  localparam int unsigned SetW  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [UTIL_W-1:0]  UpThr     = UTIL_W'(UP_THRESH);
  localparam logic [UTIL_W-1:0]  DownThr   = UTIL_W'(DOWN_THRESH);
  localparam logic [UTIL_W-1:0]  GateThr   = UTIL_W'(GATE_THRESH);
  localparam logic [7:0]         TempSet   = 8'(TEMP_LIMIT);
  localparam logic [7:0]         TempClr   = 8'(TEMP_LIMIT - TEMP_HYST);
  localparam logic [LEVEL_W-1:0] MaxLevel  = '1;
  localparam logic [LEVEL_W-1:0] LevelInit = LEVEL_W'(LEVEL_INIT);
  localparam logic [IdleW-1:0]   CgDelay   = IdleW'(CG_DELAY);
  localparam logic [IdleW-1:0]   PgDelay   = IdleW'(PG_DELAY);
  localparam logic [SetW-1:0]    SetLast   = SetW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StMeasure, StDecide, StReq, StSettle} state_e;

  state_e                 state_q, state_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic [SetW-1:0]        set_q, set_d;
  logic                   req_q, req_d;
  logic [LEVEL_W-1:0]     target_q, target_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   throttle_q, throttle_d;
  logic [UTIL_W-1:0]      metric;
  logic [UTIL_W-1:0]      avg;

  logic [IdleW-1:0]       idle_q [NUM_DOMAINS];
  logic [IdleW-1:0]       idle_d [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] pwr_q, pwr_d, clk_q, clk_d;

  assign avg = acc_q[AccW-1:WINDOW_LOG2];

  // Peak utilisation across all domains for this cycle.
  always_comb begin
    metric = '0;
    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
      if (util_flat_i[i*UTIL_W +: UTIL_W] > metric) metric = util_flat_i[i*UTIL_W +: UTIL_W];
    end
  end

  // DVFS FSM next state; window/settle counters clear whenever they are not counting.
  always_comb begin
    state_d  = state_q;
    acc_d    = '0;
    win_d    = '0;
    set_d    = '0;
    req_d    = req_q;
    target_d = target_q;
    level_d  = level_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) state_d = StMeasure;
      end
      StMeasure: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_q + AccW'(metric);
          win_d = win_q + 1'b1;
          if (&win_q) state_d = StDecide;
        end
      end
      StDecide: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (throttle_q && level_q != '0) begin
          target_d = level_q - 1'b1;
          req_d    = 1'b1;
          state_d  = StReq;
        end else if (avg > UpThr && level_q != MaxLevel && !throttle_q) begin
          target_d = level_q + 1'b1;
          req_d    = 1'b1;
          state_d  = StReq;
        end else if (avg < DownThr && level_q != '0) begin
          target_d = level_q - 1'b1;
          req_d    = 1'b1;
          state_d  = StReq;
        end else begin
          state_d = StMeasure;
        end
      end
      StReq: begin
        // Handshake is never abandoned; enable only chooses where to go afterwards.
        if (dvfs_ack_i) begin
          level_d = target_q;
          req_d   = 1'b0;
          state_d = enable_i ? StSettle : StIdle;
        end
      end
      StSettle: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (set_q == SetLast) begin
          state_d = StMeasure;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Thermal throttle with hysteresis band, independent of FSM state.
  always_comb begin
    throttle_d = throttle_q;
    if (temperature_i >= TempSet)     throttle_d = 1'b1;
    else if (temperature_i < TempClr) throttle_d = 1'b0;
  end

  // Per-domain idle counting and gating; clock only re-enabled once power is already on.
  always_comb begin
    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
      if (util_flat_i[i*UTIL_W +: UTIL_W] >= GateThr) begin
        idle_d[i] = '0;
        pwr_d[i]  = 1'b1;
        clk_d[i]  = pwr_q[i];
      end else begin
        idle_d[i] = (idle_q[i] == PgDelay) ? idle_q[i] : idle_q[i] + 1'b1;
        pwr_d[i]  = idle_q[i] < PgDelay;
        clk_d[i]  = pwr_q[i] && (idle_q[i] < CgDelay);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      win_q      <= '0;
      set_q      <= '0;
      req_q      <= 1'b0;
      target_q   <= LevelInit;
      level_q    <= LevelInit;
      throttle_q <= 1'b0;
      pwr_q      <= '1;
      clk_q      <= '1;
      for (int i = 0; i < int'(NUM_DOMAINS); i++) idle_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      win_q      <= win_d;
      set_q      <= set_d;
      req_q      <= req_d;
      target_q   <= target_d;
      level_q    <= level_d;
      throttle_q <= throttle_d;
      pwr_q      <= pwr_d;
      clk_q      <= clk_d;
      for (int i = 0; i < int'(NUM_DOMAINS); i++) idle_q[i] <= idle_d[i];
    end
  end

`ifdef PM_STATS_EN
  logic        commit;
  logic [15:0] trans_q;

  assign commit = (state_q == StReq) && dvfs_ack_i;

  // Saturating count of committed level changes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      trans_q <= '0;
    end else if (commit && trans_q != 16'hFFFF) begin
      trans_q <= trans_q + 16'd1;
    end
  end

  assign dvfs_transitions_o = trans_q;
`else
  assign dvfs_transitions_o = '0;
`endif

  assign dvfs_req_o         = req_q;
  assign dvfs_target_o      = target_q;
  assign level_o            = level_q;
  assign thermal_throttle_o = throttle_q;
  assign domain_pwr_en_o    = pwr_q;
  assign domain_clk_en_o    = clk_q;
  assign busy_o             = (state_q == StReq) || (state_q == StSettle);

endmodule

// File: tb/tb_dvfs_domain_sequencer.sv
// Directed self-checking bench for dvfs_domain_sequencer (default parameters).
module tb_dvfs_domain_sequencer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [63:0] util_flat_i;
  logic [7:0]  temperature_i;
  logic        dvfs_req_o;
  logic [2:0]  dvfs_target_o;
  logic        dvfs_ack_i;
  logic [2:0]  level_o;
  logic        thermal_throttle_o;
  logic [3:0]  domain_pwr_en_o;
  logic [3:0]  domain_clk_en_o;
  logic        busy_o;
  logic [15:0] dvfs_transitions_o;

  int checks   = 0;
  int failures = 0;
  int exp_trans = 0;
  int n;
  bit seen;

  dvfs_domain_sequencer dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .enable_i           (enable_i),
    .util_flat_i        (util_flat_i),
    .temperature_i      (temperature_i),
    .dvfs_req_o         (dvfs_req_o),
    .dvfs_target_o      (dvfs_target_o),
    .dvfs_ack_i         (dvfs_ack_i),
    .level_o            (level_o),
    .thermal_throttle_o (thermal_throttle_o),
    .domain_pwr_en_o    (domain_pwr_en_o),
    .domain_clk_en_o    (domain_clk_en_o),
    .busy_o             (busy_o),
    .dvfs_transitions_o (dvfs_transitions_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_trans(input string tag);
`ifdef PM_STATS_EN
    check(tag, 32'(dvfs_transitions_o), 32'(exp_trans));
`else
    check(tag, 32'(dvfs_transitions_o), 32'd0);
`endif
  endtask

  task automatic set_util(input logic [15:0] u0, input logic [15:0] u1,
                          input logic [15:0] u2, input logic [15:0] u3);
    util_flat_i = {u3, u2, u1, u0};
  endtask

  // Counts posedges until dvfs_req is seen at a negedge, bounded by budget.
  task automatic wait_req(input int budget, output int cycles, output bit hit);
    cycles = 0;
    hit    = 1'b0;
    while (!hit && cycles < budget) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (dvfs_req_o) hit = 1'b1;
    end
  endtask

  // One-cycle ack pulse, starting and ending at a negedge.
  task automatic do_ack();
    dvfs_ack_i = 1'b1;
    @(posedge clk);
    #1 dvfs_ack_i = 1'b0;
    @(negedge clk);
  endtask

  // Clock must never run on an unpowered domain.
  always @(negedge clk) begin
    if (!reset_i) check("inv_clk_implies_pwr", 32'(domain_clk_en_o & ~domain_pwr_en_o), 32'd0);
  end

  initial begin
    reset_i       = 1'b1;
    enable_i      = 1'b0;
    dvfs_ack_i    = 1'b0;
    temperature_i = 8'd40;
    set_util(16'd20000, 16'd20000, 16'd20000, 16'd20000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 32'(level_o), 32'd3);
    check("rst_req", 32'(dvfs_req_o), 32'd0);
    check("rst_target", 32'(dvfs_target_o), 32'd3);
    check("rst_throttle", 32'(thermal_throttle_o), 32'd0);
    check("rst_pwr", 32'(domain_pwr_en_o), 32'hF);
    check("rst_clk", 32'(domain_clk_en_o), 32'hF);
    check("rst_busy", 32'(busy_o), 32'd0);
    check_trans("rst_trans");
    reset_i = 1'b0;

    // High utilisation: step up 3 -> 7.
    set_util(16'd50000, 16'd50000, 16'd50000, 16'd50000);
    enable_i = 1'b1;
    wait_req(400, n, seen);
    check("up_req_seen", 32'(seen), 32'd1);
    check("up_first_latency", 32'(n), 32'd130);
    check("up_target4", 32'(dvfs_target_o), 32'd4);
    check("up_level_before_ack", 32'(level_o), 32'd3);
    check("up_busy_req", 32'(busy_o), 32'd1);
    repeat (4) @(negedge clk);
    check("up_req_held", 32'(dvfs_req_o), 32'd1);
    check("up_target_stable", 32'(dvfs_target_o), 32'd4);
    do_ack();
    exp_trans++;
    check("up_level4", 32'(level_o), 32'd4);
    check("up_req_dropped", 32'(dvfs_req_o), 32'd0);
    check("up_busy_settle", 32'(busy_o), 32'd1);
    check_trans("up_trans1");
    for (int k = 5; k <= 7; k++) begin
      wait_req(400, n, seen);
      check("up_loop_seen", 32'(seen), 32'd1);
      check("up_loop_latency", 32'(n), 32'd179);
      check("up_loop_target", 32'(dvfs_target_o), 32'(k));
      do_ack();
      exp_trans++;
      check("up_loop_level", 32'(level_o), 32'(k));
    end
    check_trans("up_trans4");
    wait_req(400, n, seen);
    check("sat_no_req", 32'(seen), 32'd0);
    check("sat_level7", 32'(level_o), 32'd7);

    // Mid-band utilisation: no change over ten windows.
    set_util(16'd20000, 16'd20000, 16'd20000, 16'd20000);
    wait_req(1400, n, seen);
    check("mid_no_req", 32'(seen), 32'd0);
    check("mid_level7", 32'(level_o), 32'd7);

    // Thermal throttle: step down to 0 despite high utilisation.
    set_util(16'd50000, 16'd50000, 16'd50000, 16'd50000);
    temperature_i = 8'd90;
    @(posedge clk);
    @(negedge clk);
    check("thr_set", 32'(thermal_throttle_o), 32'd1);
    for (int k = 6; k >= 0; k--) begin
      wait_req(400, n, seen);
      check("thr_loop_seen", 32'(seen), 32'd1);
      check("thr_loop_target", 32'(dvfs_target_o), 32'(k));
      do_ack();
      exp_trans++;
      check("thr_loop_level", 32'(level_o), 32'(k));
    end
    wait_req(400, n, seen);
    check("thr_floor_no_req", 32'(seen), 32'd0);
    check("thr_floor_level0", 32'(level_o), 32'd0);
    temperature_i = 8'd82;
    @(posedge clk);
    @(negedge clk);
    check("thr_hyst_hold", 32'(thermal_throttle_o), 32'd1);
    temperature_i = 8'd79;
    @(posedge clk);
    @(negedge clk);
    check("thr_clear", 32'(thermal_throttle_o), 32'd0);
    wait_req(400, n, seen);
    check("thr_resume_seen", 32'(seen), 32'd1);
    check("thr_resume_target", 32'(dvfs_target_o), 32'd1);
    do_ack();
    exp_trans++;
    check("thr_resume_level", 32'(level_o), 32'd1);
    check_trans("thr_trans");

    // Domain gating with the DVFS loop idle.
    enable_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("dis_busy", 32'(busy_o), 32'd0);
    set_util(16'd50000, 16'd50000, 16'd0, 16'd50000);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("cg_before", 32'(domain_clk_en_o), 32'hF);
    @(posedge clk);
    @(negedge clk);
    check("cg_after", 32'(domain_clk_en_o), 32'b1011);
    check("cg_pwr_on", 32'(domain_pwr_en_o), 32'hF);
    repeat (239) @(posedge clk);
    @(negedge clk);
    check("pg_before", 32'(domain_pwr_en_o), 32'hF);
    @(posedge clk);
    @(negedge clk);
    check("pg_after", 32'(domain_pwr_en_o), 32'b1011);
    check("pg_clk", 32'(domain_clk_en_o), 32'b1011);
    set_util(16'd50000, 16'd50000, 16'd500, 16'd50000);
    @(posedge clk);
    @(negedge clk);
    check("wake_pwr_n1", 32'(domain_pwr_en_o), 32'hF);
    check("wake_clk_n1", 32'(domain_clk_en_o), 32'b1011);
    set_util(16'd50000, 16'd50000, 16'd0, 16'd50000);
    @(posedge clk);
    @(negedge clk);
    check("wake_clk_n2", 32'(domain_clk_en_o), 32'hF);
    set_util(16'd50000, 16'd0, 16'd0, 16'd50000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("cg2_clk", 32'(domain_clk_en_o), 32'b1001);
    check("cg2_pwr", 32'(domain_pwr_en_o), 32'hF);
    set_util(16'd50000, 16'd500, 16'd0, 16'd50000);
    @(posedge clk);
    @(negedge clk);
    check("wake_powered_clk", 32'(domain_clk_en_o), 32'b1011);

    // Disable during REQ: handshake completes, then idle.
    set_util(16'd50000, 16'd50000, 16'd50000, 16'd50000);
    enable_i = 1'b1;
    wait_req(400, n, seen);
    check("dreq_seen", 32'(seen), 32'd1);
    check("dreq_latency", 32'(n), 32'd130);
    check("dreq_target", 32'(dvfs_target_o), 32'd2);
    enable_i = 1'b0;
    repeat (5) @(negedge clk);
    check("dreq_req_held", 32'(dvfs_req_o), 32'd1);
    check("dreq_busy", 32'(busy_o), 32'd1);
    do_ack();
    exp_trans++;
    check("dreq_level", 32'(level_o), 32'd2);
    check("dreq_req_low", 32'(dvfs_req_o), 32'd0);
    check("dreq_idle", 32'(busy_o), 32'd0);
    check_trans("dreq_trans");
    wait_req(300, n, seen);
    check("dreq_no_more_req", 32'(seen), 32'd0);
    do_ack();
    check("stray_ack_level", 32'(level_o), 32'd2);
    check("stray_ack_req", 32'(dvfs_req_o), 32'd0);
    check("stray_ack_busy", 32'(busy_o), 32'd0);
    check_trans("stray_ack_trans");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
